// File: rtl/sys_led_monitor.sv
// Board-level LED debug monitor: shows one LED_W-bit slice of a selected probe
// word, with static, timed scroll, frozen-snapshot scroll and button-step modes.
module sys_led_monitor #(
    parameter  int CHANNELS = 8,
    parameter  int DATA_W   = 32,
    parameter  int LED_W    = 8,
    parameter  int DIVISOR  = 1,
    localparam int SEL_W    = $clog2(CHANNELS),
    localparam int NSLICE   = DATA_W / LED_W,
    localparam int IDX_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic                       clk,
    input  logic                       SYS_reset_n,
    input  logic [SEL_W-1:0]           SYS_output_sel,
    input  logic [1:0]                 SYS_mode,
    input  logic                       SYS_step,
    input  logic [CHANNELS*DATA_W-1:0] ch_data,
    output logic [LED_W-1:0]           SYS_leds,
    output logic [IDX_W-1:0]           slice_idx,
    output logic                       tick
);

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_SCROLL = 2'b01;
    localparam logic [1:0] MODE_SNAP   = 2'b10;
    localparam logic [1:0] MODE_STEP   = 2'b11;

    localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] SLICE_LAST = IDX_W'(NSLICE - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [IDX_W-1:0]  slice_q, slice_d;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic [1:0]        mode_q;
    logic [SEL_W-1:0]  sel_q;
    logic [2:0]        sync_q, sync_d;

    logic [DATA_W-1:0] live_w, src_w;
    logic              restart_w, advance_w, step_edge_w;

    // Out-of-range selects fall through to the all-zero default.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        live_w = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (SYS_output_sel == SEL_W'(c)) begin
                live_w = ch_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign src_w = (SYS_mode == MODE_SNAP) ? snap_q : live_w;

    always_comb begin
        leds_d = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (slice_q == IDX_W'(s)) begin
                leds_d = src_w[s*LED_W +: LED_W];
            end
        end
    end

    // tick is registered from the next count so it stays aligned with cnt_q == DIVISOR-1.
    assign cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    assign tick_d = (cnt_d == CNT_LAST);

    // sync_q[1] is the synchronised button, sync_q[2] its delayed copy.
    assign sync_d      = {sync_q[1:0], SYS_step};
    assign step_edge_w = sync_q[1] & ~sync_q[2];

    assign restart_w = (SYS_mode != mode_q) || (SYS_output_sel != sel_q);

    always_comb begin
        advance_w = 1'b0;
        case (SYS_mode)
            MODE_SCROLL, MODE_SNAP: advance_w = tick_q;
            MODE_STEP:              advance_w = step_edge_w;
            default:                advance_w = 1'b0;
        endcase
    end

    always_comb begin
        slice_d = slice_q;
        if (restart_w) begin
            slice_d = '0;
        end else if (advance_w) begin
            slice_d = (slice_q == SLICE_LAST) ? '0 : slice_q + IDX_W'(1);
        end
    end

    assign snap_d = (restart_w && (SYS_mode == MODE_SNAP)) ? live_w : snap_q;

    always_ff @(posedge clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            slice_q <= '0;
            leds_q  <= '0;
            snap_q  <= '0;
            mode_q  <= MODE_STATIC;
            sel_q   <= '0;
            sync_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            slice_q <= slice_d;
            leds_q  <= leds_d;
            snap_q  <= snap_d;
            mode_q  <= SYS_mode;
            sel_q   <= SYS_output_sel;
            sync_q  <= sync_d;
        end
    end

    assign SYS_leds  = leds_q;
    assign slice_idx = slice_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_sys_led_monitor.sv
// Self-checking bench for sys_led_monitor: directed scenarios plus random
// stimulus, all compared against a cycle-level behavioural model.
module tb_sys_led_monitor;

    localparam int CH  = 4;
    localparam int DW  = 32;
    localparam int LW  = 8;
    localparam int DIV = 4;
    localparam int NS  = DW / LW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        sel;
    logic [1:0]        mode;
    logic              step;
    logic [CH*DW-1:0]  ch_data;
    logic [LW-1:0]     leds;
    logic [1:0]        sidx;
    logic              tick;

    // Second instance: five channels so an out-of-range select is encodable.
    logic [2:0]        sel5;
    logic [1:0]        mode5;
    logic              step5;
    logic [5*DW-1:0]   ch5;
    logic [LW-1:0]     leds5;
    logic [1:0]        sidx5;
    logic              tick5;

    sys_led_monitor #(.CHANNELS(CH), .DATA_W(DW), .LED_W(LW), .DIVISOR(DIV)) dut (
        .clk            (clk),
        .SYS_reset_n    (rst_n),
        .SYS_output_sel (sel),
        .SYS_mode       (mode),
        .SYS_step       (step),
        .ch_data        (ch_data),
        .SYS_leds       (leds),
        .slice_idx      (sidx),
        .tick           (tick)
    );

    sys_led_monitor #(.CHANNELS(5), .DATA_W(DW), .LED_W(LW), .DIVISOR(1)) dut5 (
        .clk            (clk),
        .SYS_reset_n    (rst_n),
        .SYS_output_sel (sel5),
        .SYS_mode       (mode5),
        .SYS_step       (step5),
        .ch_data        (ch5),
        .SYS_leds       (leds5),
        .slice_idx      (sidx5),
        .tick           (tick5)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int          m_cnt, m_slice;
    logic [31:0] m_snap;
    logic [1:0]  m_mode, m_sel;
    logic        m_s1, m_s2, m_s3;
    logic [7:0]  m_leds;

    bit          rec_en;
    logic [7:0]  rec_leds[$];
    int          rec_tick[$];
    int          rec_n;
    logic [7:0]  run_v[$];
    int          run_l[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] chan(input int s);
        if (s >= CH) return 32'h0;
        return ch_data[s*DW +: DW];
    endfunction

    task automatic set_ch(input int s, input logic [31:0] v);
        ch_data[s*DW +: DW] = v;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_slice = 0; m_snap = '0; m_mode = 2'b00; m_sel = 2'b00;
        m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0; m_leds = '0;
    endtask

    // One clock: predict from pre-edge inputs, step, then compare at the negedge.
    task automatic cyc();
        logic [31:0] live, src;
        bit          restart, adv;
        int          n_slice;
        live    = chan(int'(sel));
        src     = (mode == 2'b10) ? m_snap : live;
        restart = (mode != m_mode) || (sel != m_sel);
        case (mode)
            2'b01, 2'b10: adv = (m_cnt == DIV - 1);
            2'b11:        adv = m_s2 && !m_s3;
            default:      adv = 1'b0;
        endcase
        n_slice = restart ? 0 : (adv ? (m_slice + 1) % NS : m_slice);
        @(posedge clk);
        if (rst_n) begin
            m_leds = 8'(src >> (8 * m_slice));
            if (restart && mode == 2'b10) m_snap = live;
            m_slice = n_slice;
            m_cnt   = (m_cnt + 1) % DIV;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = step;
            m_mode = mode; m_sel = sel;
        end
        @(negedge clk);
        check("model_leds", leds, m_leds);
        check("model_slice", sidx, m_slice);
        check("model_tick", tick, m_cnt == DIV - 1);
        if (rec_en) begin
            rec_leds.push_back(leds);
            if (tick) rec_tick.push_back(rec_n);
            rec_n++;
        end
    endtask

    task automatic rec_start();
        rec_leds.delete(); rec_tick.delete(); rec_n = 0; rec_en = 1'b1;
    endtask

    task automatic build_runs();
        run_v.delete(); run_l.delete();
        foreach (rec_leds[i]) begin
            if (run_v.size() == 0 || run_v[run_v.size()-1] != rec_leds[i]) begin
                run_v.push_back(rec_leds[i]);
                run_l.push_back(1);
            end else begin
                run_l[run_l.size()-1]++;
            end
        end
    endtask

    task automatic press(input int hold);
        step = 1'b1;
        repeat (hold) cyc();
        step = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        logic [7:0] exp_scroll[5];
        logic [7:0] exp_snap[4];
        int         guard;
        exp_scroll = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
        exp_snap   = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

        rst_n = 1'b0; sel = '0; mode = '0; step = 1'b0; ch_data = '0;
        sel5 = '0; mode5 = '0; step5 = 1'b0; ch5 = {5{32'hFFFF_FFFF}};
        rec_en = 1'b0; rec_n = 0;
        model_reset();
        #1;
        check("rst_leds", leds, 0);
        check("rst_slice", sidx, 0);
        check("rst_tick", tick, 0);
        check("rst_tick_div1", tick5, 0);
        check("rst_slice_div1", sidx5, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("div1_tick_high", tick5, 1);
        check("ch5_sel0", leds5, 8'hFF);

        // STATIC
        set_ch(2, 32'hDEADBEEF); sel = 2'd2;
        cyc();
        check("static_ef", leds, 8'hEF);
        set_ch(2, 32'h12345678);
        cyc();
        check("static_live_78", leds, 8'h78);
        sel5 = 3'd5;
        repeat (2) cyc();
        check("static_sel_oor", leds5, 8'h00);
        check("div1_tick_still_high", tick5, 1);

        // SCROLL
        set_ch(1, 32'h11223344); sel = 2'd1; mode = 2'b01;
        rec_start();
        repeat (24) cyc();
        rec_en = 1'b0;
        build_runs();
        check("scroll_run_count_ok", run_v.size() >= 5, 1);
        if (run_v.size() >= 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("scroll_val%0d", i), run_v[i], exp_scroll[i]);
            for (int i = 1; i < 4; i++) check($sformatf("scroll_hold%0d", i), run_l[i], 4);
        end
        check("scroll_tick_count", rec_tick.size() >= 5, 1);
        for (int i = 1; i < rec_tick.size(); i++)
            check($sformatf("scroll_tick_gap%0d", i), rec_tick[i] - rec_tick[i-1], 4);

        // Reset mid-scroll at slice 2, no clock edge involved
        guard = 0;
        while (m_slice != 2 && guard < 20) begin cyc(); guard++; end
        check("reach_slice2", sidx, 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_leds", leds, 0);
        check("midrst_slice", sidx, 0);
        check("midrst_tick", tick, 0);
        model_reset();
        mode = 2'b00; sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) cyc();
        check("post_rst_static_slice", sidx, 0);

        // SNAPSHOT
        set_ch(0, 32'hA1B2C3D4);
        cyc();
        mode = 2'b10;
        cyc();
        set_ch(0, 32'h0);
        rec_start();
        repeat (20) cyc();
        rec_en = 1'b0;
        build_runs();
        check("snap_run_count_ok", run_v.size() >= 4, 1);
        if (run_v.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("snap_val%0d", i), run_v[i], exp_snap[i]);
            for (int i = 1; i < 3; i++) check($sformatf("snap_hold%0d", i), run_l[i], 4);
        end

        // STEP: a press in mode 00 must be ignored
        mode = 2'b00; sel = 2'd3; set_ch(3, 32'h0A0B0C0D);
        repeat (2) cyc();
        press(6);
        check("step_ignored_slice", sidx, 0);
        mode = 2'b11;
        repeat (3) cyc();
        check("step_init_0d", leds, 8'h0D);
        for (int p = 0; p < 2; p++) begin
            step = 1'b1;
            cyc();
            cyc();
            check($sformatf("step%0d_k1_slice", p), sidx, p);
            cyc();
            check($sformatf("step%0d_k2_slice", p), sidx, p + 1);
            cyc();
            check($sformatf("step%0d_k3_leds", p), leds, (p == 0) ? 8'h0C : 8'h0B);
            repeat (2) cyc();
            step = 1'b0;
            repeat (4) cyc();
            check($sformatf("step%0d_once", p), sidx, p + 1);
        end

        // Restart colliding with tick at slice 2
        mode = 2'b01; sel = 2'd1;
        guard = 0;
        cyc();
        while (!(m_slice == 2 && m_cnt == DIV - 1) && guard < 40) begin cyc(); guard++; end
        check("collide_setup_tick", tick, 1);
        check("collide_setup_slice", sidx, 2);
        sel = 2'd2;
        cyc();
        check("collide_slice0", sidx, 0);
        cyc();
        check("collide_leds_78", leds, 8'h78);

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) mode = 2'($urandom);
            if ($urandom_range(19) == 0) sel = 2'($urandom);
            if ($urandom_range(7) == 0) set_ch(int'($urandom_range(CH - 1)), $urandom);
            if ($urandom_range(4) == 0) step = ~step;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
